// File: rtl/serial_chunk_adder.sv
// serial_chunk_adder
//   Multi-cycle WIDTH-bit adder/subtractor. Operands are captured on an
//   in_valid/in_ready handshake. The adder then processes CHUNK bits per clock
//   through a ripple chain of full_adder cells, and the carry between chunks
//   is kept in a register. The result is held with out_valid until the
//   consumer raises out_ready.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operands valid            in_ready   block can accept operands
//   a, b       WIDTH-bit operands        cin        carry-in (add mode only)
//   sub        1: a - b (cin ignored)
//   out_valid  result valid, held        out_ready  consumer accepts result
//   sum        result modulo 2^WIDTH
//   cout       carry out of the MSB (in sub mode, 1 = no borrow)
//   overflow   two's-complement overflow (carry into MSB ^ carry out of MSB)
`timescale 1ns/1ps

// One-bit full adder cell; the chunk adder below is a ripple chain of these.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module serial_chunk_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             overflow
);

  localparam int NCH = WIDTH / CHUNK;
  localparam int CW  = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCH - 1);

  if (WIDTH < 1 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_bad_params
    $error("serial_chunk_adder: CHUNK must lie in 1..WIDTH and divide WIDTH");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t            state;
  logic [WIDTH-1:0]  a_reg;
  logic [WIDTH-1:0]  b_reg;   // already inverted for subtraction
  logic              carry;
  logic [CW-1:0]     cnt;

  logic [CHUNK-1:0]  a_ch;
  logic [CHUNK-1:0]  b_ch;
  logic [CHUNK-1:0]  s_ch;
  logic [CHUNK:0]    c;       // c[i] = carry into bit i of the current chunk

  // Select chunk cnt of each captured operand.
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    a_ch = '0;
    b_ch = '0;
    for (int k = 0; k < NCH; k++) begin
      if (cnt == CW'(k)) begin
        a_ch = a_reg[k*CHUNK +: CHUNK];
        b_ch = b_reg[k*CHUNK +: CHUNK];
      end
    end
  end

  assign c[0] = carry;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    full_adder u_fa (
      .a  (a_ch[i]),
      .b  (b_ch[i]),
      .ci (c[i]),
      .s  (s_ch[i]),
      .co (c[i+1])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: operand and result registers are cleared on reset along with the
    // control state. They are plain flops, not a memory array, and this keeps
    // sum/cout/overflow at the documented zero after reset.
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      overflow  <= 1'b0;
      cnt       <= '0;
      carry     <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // register samples pre-edge values regardless of statement order.
      case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            a_reg    <= a;
            // Subtraction is a + ~b + 1, so the +1 enters through the carry.
            b_reg    <= sub ? ~b : b;
            carry    <= sub ? 1'b1 : cin;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= RUN;
          end
        end

        RUN: begin
          for (int k = 0; k < NCH; k++) begin
            if (cnt == CW'(k)) sum[k*CHUNK +: CHUNK] <= s_ch;
          end
          carry <= c[CHUNK];
          if (cnt == LAST) begin
            // On the last chunk, c[CHUNK-1] is the carry into bit WIDTH-1.
            cout      <= c[CHUNK];
            overflow  <= c[CHUNK-1] ^ c[CHUNK];
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_chunk_adder.sv
// tb_serial_chunk_adder
//   Scoreboard bench for serial_chunk_adder. Drivers push expected results
//   (with the accept edge number) into queues. Monitors compare each
//   presented result and its latency. The bench uses a WIDTH=16/CHUNK=4
//   instance for directed vectors, handshake hold and mid-operation reset.
//   It also uses three WIDTH=4 instances (CHUNK 1, 2, 4) for an exhaustive
//   sweep.
`timescale 1ns/1ps

module tb_serial_chunk_adder;

  localparam int NCH = 4;

  typedef struct {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
    int          acc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic rst_sw_n;
  bit   go = 1'b0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=0x%0h expected=0x%0h (t=%0t)", name, act, exp, $time);
  endtask

  // Reference model: integer add of a, effective b and carry-in.
  // Overflow occurs when the operand signs agree and the result sign differs.
  function automatic exp_t model4(input logic [3:0] av, input logic [3:0] bv,
                                  input logic ci, input logic sb);
    logic [3:0] be;
    logic [4:0] full;
    exp_t       e;
    be     = sb ? ~bv : bv;
    full   = {1'b0, av} + {1'b0, be} + {4'b0, (sb ? 1'b1 : ci)};
    e.sum  = {12'b0, full[3:0]};
    e.cout = full[4];
    e.ovf  = (av[3] == be[3]) && (full[3] != av[3]);
    e.acc  = 0;
    return e;
  endfunction

  // ---------------- main 16/4 instance ----------------
  logic        m_in_valid, m_in_ready, m_cin, m_sub, m_out_valid, m_out_ready;
  logic        m_cout, m_ovf;
  logic [15:0] m_a, m_b, m_sum;

  serial_chunk_adder #(.WIDTH(16), .CHUNK(4)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (m_in_valid),
    .in_ready  (m_in_ready),
    .a         (m_a),
    .b         (m_b),
    .cin       (m_cin),
    .sub       (m_sub),
    .out_valid (m_out_valid),
    .out_ready (m_out_ready),
    .sum       (m_sum),
    .cout      (m_cout),
    .overflow  (m_ovf)
  );

  exp_t mq[$];
  bit   m_prev_ov = 1'b0;

  // Present an operation starting at a negedge; returns at the negedge after
  // the accept edge, with operands scrambled to show they were captured.
  task automatic send(input logic [15:0] av, input logic [15:0] bv,
                      input logic ci, input logic sb,
                      input logic [15:0] es, input logic ec, input logic eo,
                      input bit push);
    int   w;
    exp_t e;
    m_a = av; m_b = bv; m_cin = ci; m_sub = sb; m_in_valid = 1'b1;
    w = 0;
    while (!m_in_ready && w < 50) begin @(negedge clk); w++; end
    check("m_accept_wait", 32'(m_in_ready), 32'd1);
    e.sum = es; e.cout = ec; e.ovf = eo; e.acc = cyc + 1;
    if (push) mq.push_back(e);
    @(negedge clk);
    m_in_valid = 1'b0;
    m_a = 16'hDEAD; m_b = 16'hBEEF; m_cin = ~ci; m_sub = ~sb;
  endtask

  always @(negedge clk) begin
    #1;
    if (rst_n && m_out_valid) begin
      if (mq.size() == 0) begin
        check("m_spurious_out_valid", 32'(m_out_valid), 32'd0);
      end else begin
        if (!m_prev_ov) check("m_latency", 32'(cyc - mq[0].acc), 32'(NCH));
        check("m_result", 32'({m_sum, m_cout, m_ovf}),
              32'({mq[0].sum, mq[0].cout, mq[0].ovf}));
        if (m_out_ready) void'(mq.pop_front());
      end
    end
    m_prev_ov <= m_out_valid && rst_n;
  end

  // ---------------- exhaustive WIDTH=4 sweep ----------------
  for (genvar gi = 0; gi < 3; gi++) begin : g_sw
    localparam int CH = (gi == 0) ? 1 : ((gi == 1) ? 2 : 4);
    localparam int SN = 4 / CH;

    logic       iv, ir, ci, sb, ov, orr, co, of;
    logic [3:0] sa, sbb, ss;
    exp_t       q[$];
    bit         prev_ov = 1'b0;
    bit         done = 1'b0;

    serial_chunk_adder #(.WIDTH(4), .CHUNK(CH)) u_dut (
      .clk       (clk),
      .rst_n     (rst_sw_n),
      .in_valid  (iv),
      .in_ready  (ir),
      .a         (sa),
      .b         (sbb),
      .cin       (ci),
      .sub       (sb),
      .out_valid (ov),
      .out_ready (orr),
      .sum       (ss),
      .cout      (co),
      .overflow  (of)
    );

    initial begin
      logic [9:0] vb;
      exp_t       e;
      int         w;
      iv = 1'b0; sa = '0; sbb = '0; ci = 1'b0; sb = 1'b0; orr = 1'b1;
      wait (go);
      @(negedge clk);
      for (int v = 0; v < 1024; v++) begin
        vb = 10'(v);
        sa = vb[3:0]; sbb = vb[7:4]; ci = vb[8]; sb = vb[9]; iv = 1'b1;
        w = 0;
        while (!ir && w < 20) begin @(negedge clk); w++; end
        check($sformatf("sw%0d_accept_wait", CH), 32'(ir), 32'd1);
        e = model4(sa, sbb, ci, sb);
        e.acc = cyc + 1;
        q.push_back(e);
        @(negedge clk);
      end
      iv = 1'b0;
      w = 0;
      while (q.size() != 0 && w < 50) begin @(negedge clk); w++; end
      check($sformatf("sw%0d_drained", CH), 32'(q.size()), 32'd0);
      done = 1'b1;
    end

    always @(negedge clk) begin
      #1;
      if (rst_sw_n && ov) begin
        if (q.size() == 0) begin
          check($sformatf("sw%0d_spurious_out_valid", CH), 32'(ov), 32'd0);
        end else begin
          if (!prev_ov) check($sformatf("sw%0d_latency", CH), 32'(cyc - q[0].acc), 32'(SN));
          check($sformatf("sw%0d_result", CH), 32'({ss, co, of}),
                32'({q[0].sum[3:0], q[0].cout, q[0].ovf}));
          if (orr) void'(q.pop_front());
        end
      end
      prev_ov <= ov && rst_sw_n;
    end
  end

  wire sweep_done = g_sw[0].done && g_sw[1].done && g_sw[2].done;

  // ---------------- main sequence ----------------
  initial begin
    int w;
    rst_n = 1'b0; rst_sw_n = 1'b0;
    m_in_valid = 1'b0; m_a = '0; m_b = '0; m_cin = 1'b0; m_sub = 1'b0; m_out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1; rst_sw_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready",  32'(m_in_ready),  32'd1);
    check("rst_out_valid", 32'(m_out_valid), 32'd0);
    check("rst_sum",       32'(m_sum),       32'd0);
    check("rst_cout",      32'(m_cout),      32'd0);
    check("rst_overflow",  32'(m_ovf),       32'd0);
    go = 1'b1;

    // Directed vectors: a, b, cin, sub -> sum, cout, overflow
    send(16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    send(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b1);
    send(16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b1);
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b1);
    send(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b1);
    send(16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0, 1'b1);
    send(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);
    send(16'hA5A5, 16'h5A5A, 1'b0, 1'b1, 16'h4B4B, 1'b1, 1'b1, 1'b1);

    // Hold the result with out_ready low. New operands offered meanwhile
    // must not be accepted.
    send(16'h00FF, 16'h0F0F, 1'b1, 1'b0, 16'h100F, 1'b0, 1'b0, 1'b1);
    m_out_ready = 1'b0;
    w = 0;
    while (!m_out_valid && w < 20) begin @(negedge clk); w++; end
    check("hold_reached", 32'(m_out_valid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      m_in_valid = (i % 2 == 0);
      m_a = 16'(16'h1111 * (i + 1)); m_b = 16'h2222; m_sub = 1'b0;
      #2;
      check("hold_in_ready",  32'(m_in_ready),  32'd0);
      check("hold_out_valid", 32'(m_out_valid), 32'd1);
    end
    @(negedge clk);
    m_in_valid = 1'b0;
    m_out_ready = 1'b1;
    @(negedge clk);
    #2;
    check("release_out_valid", 32'(m_out_valid), 32'd0);
    check("release_in_ready",  32'(m_in_ready),  32'd1);

    // Asynchronous reset in the second RUN cycle aborts the operation.
    send(16'h1234, 16'h1111, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_in_ready",  32'(m_in_ready),  32'd1);
    check("arst_out_valid", 32'(m_out_valid), 32'd0);
    check("arst_sum",       32'(m_sum),       32'd0);
    check("arst_cout",      32'(m_cout),      32'd0);
    check("arst_overflow",  32'(m_ovf),       32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    check("post_rst_in_ready",  32'(m_in_ready),  32'd1);
    check("post_rst_out_valid", 32'(m_out_valid), 32'd0);

    send(16'h0F0F, 16'h0101, 1'b0, 1'b1, 16'h0E0E, 1'b1, 1'b0, 1'b1);

    w = 0;
    while (mq.size() != 0 && w < 100) begin @(negedge clk); w++; end
    check("m_drained", 32'(mq.size()), 32'd0);

    w = 0;
    while (!sweep_done && w < 20000) begin @(negedge clk); w++; end
    check("sweep_done", 32'(sweep_done), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  // Watchdog: if the run never completes, record a failure and still report.
  initial begin
    #400000;
    check("watchdog_sweep_done", 32'(sweep_done), 32'd1);
    check("watchdog_main_drained", 32'(mq.size()), 32'd0);
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
